i2s_tx: RTL and testbench

// - I2S master transmitter. Generates i2s_clk and i2s_ws from the system clock and shifts stereo PCM samples out on i2s_sd.
// - Philips I2S framing: 2 x 32-bit slots, MSB first. Drives an external DAC/amplifier and mirrors the receive path of i2s_fpga.
// - Fed from a FIFO through a valid/ready port with a one-entry holding register. Sends silence on underrun.

---
 rtl/i2s_tx_if.sv | 32 +++
 rtl/i2s_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_tx.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_if
// Sample stream interface into the I2S transmitter.
//   sample_valid  upstream holds a stereo pair
//   sample_left   left sample, two's complement, DATA_SIZE bits
//   sample_right  right sample, two's complement, DATA_SIZE bits
//   sample_ready  transmitter holding register is empty
// A pair moves when sample_valid && sample_ready at a clk rising edge.
// Modports: master = sample source (FIFO side), slave = transmitter.
// ---------------------------------------------------------------------------
interface i2s_tx_if #(
    parameter int DATA_SIZE = 24
);
    logic                 sample_valid;
    logic [DATA_SIZE-1:0] sample_left;
    logic [DATA_SIZE-1:0] sample_right;
    logic                 sample_ready;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// I2S master transmitter, Philips framing: two 32-bit slots per frame, MSB
// first, samples left-justified in each slot and zero padded. SCK and WS are
// generated here from the system clock; one stereo pair is taken from a
// one-entry holding register per frame, silence is sent when it is empty.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_enable      1 = run bit clock and framing, 0 = synchronous idle
//   s_if          sample stream (slave side): valid / left / right / ready
//   o_i2s_clk     bit clock (SCK)
//   o_i2s_ws      word select, 0 = left slot, 1 = right slot
//   o_i2s_sd      serial data
//   o_frame_start 1-clk pulse when a frame loads into the shifter
//   o_underrun    1-clk pulse when a frame loads with the holding reg empty
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000,
    parameter int DATA_SIZE    = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    i2s_tx_if.slave     s_if,
    output logic        o_i2s_clk,
    output logic        o_i2s_ws,
    output logic        o_i2s_sd,
    output logic        o_frame_start,
    output logic        o_underrun
);

    localparam int HALF  = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    if (HALF < 2) begin : g_half_check
        $error("i2s_tx: CLK_FREQ/(2*I2S_CLK_FREQ) must be at least 2");
    end
    if (DATA_SIZE < 1 || DATA_SIZE > 32) begin : g_size_check
        $error("i2s_tx: DATA_SIZE must be in 1..32");
    end

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;
    logic [5:0]       r_bit_cnt;
    logic             r_ws;
    logic             r_sd;
    logic [63:0]      r_shift;
    logic [63:0]      r_hold;
    logic             r_hold_empty;
    logic             r_frame_start;
    logic             r_underrun;

    logic             w_tick;
    logic             w_fall;
    logic [5:0]       w_bit_next;
    logic             w_load;
    logic             w_accept;
    logic [31:0]      w_slot_l;
    logic [31:0]      w_slot_r;

    // Frame word: bit 63 is the left MSB, so bit_cnt k selects bit 63-k.
    assign w_slot_l   = 32'(s_if.sample_left)  << (32 - DATA_SIZE);
    assign w_slot_r   = 32'(s_if.sample_right) << (32 - DATA_SIZE);

    assign w_tick     = i_enable && (r_div_cnt == DIV_LAST);
    assign w_fall     = w_tick && r_sck;
    assign w_bit_next = r_bit_cnt + 6'd1;
    assign w_load     = w_fall && (w_bit_next == 6'd63);
    assign w_accept   = s_if.sample_valid && r_hold_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_sck         <= 1'b0;
            r_bit_cnt     <= 6'd62;
            r_ws          <= 1'b0;
            r_sd          <= 1'b0;
            r_shift       <= '0;
            r_hold_empty  <= 1'b1;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (!i_enable) begin
                // Idle drops the frame in flight; bit_cnt=62 makes the first
                // fall after re-enable a frame load.
                r_div_cnt <= '0;
                r_sck     <= 1'b0;
                r_ws      <= 1'b0;
                r_sd      <= 1'b0;
                r_bit_cnt <= 6'd62;
                r_shift   <= '0;
            end else begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sck     <= ~r_sck;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end

                if (w_fall) begin
                    r_bit_cnt <= w_bit_next;
                    // Old shifter contents still drive the bit entering 63,
                    // which is the right-slot LSB of the outgoing frame.
                    r_sd      <= r_shift[~w_bit_next];
                    if (w_bit_next == 6'd31) begin
                        r_ws <= 1'b1;
                    end else if (w_bit_next == 6'd63) begin
                        r_ws <= 1'b0;
                    end
                end

                if (w_load) begin
                    r_shift       <= r_hold_empty ? 64'd0 : r_hold;
                    r_frame_start <= 1'b1;
                    r_underrun    <= r_hold_empty;
                end
            end

            // A pair accepted on a load cycle lands after the load: hold
            // ends up full and the pair waits for the next frame.
            if (w_accept) begin
                r_hold_empty <= 1'b0;
            end else if (w_load) begin
                r_hold_empty <= 1'b1;
            end
        end
    end

    // Payload only; validity is tracked by r_hold_empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= {w_slot_l, w_slot_r};
        end
    end

    assign s_if.sample_ready = r_hold_empty;
    assign o_i2s_clk         = r_sck;
    assign o_i2s_ws          = r_ws;
    assign o_i2s_sd          = r_sd;
    assign o_frame_start     = r_frame_start;
    assign o_underrun        = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Self-checking bench for i2s_tx at default parameters (HALF=33).
// A reference model derives every expected output from elapsed clock count
// since enable: SCK toggles every HALF clocks, a frame loads every 128*HALF
// clocks starting at 2*HALF-1, bit position follows from the number of SCK
// falls. The holding register is modelled as a one-entry buffer.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int H     = 33;
    localparam int DS    = 24;
    localparam int FRAME = 128 * H;

    logic clk;
    logic rst_n;
    logic en;
    logic sck, ws, sd, fs, ur;

    i2s_tx_if #(.DATA_SIZE(DS)) bus ();

    i2s_tx #(
        .CLK_FREQ     (100_000_000),
        .I2S_CLK_FREQ (1_500_000),
        .DATA_SIZE    (DS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (en),
        .s_if          (bus),
        .o_i2s_clk     (sck),
        .o_i2s_ws      (ws),
        .o_i2s_sd      (sd),
        .o_frame_start (fs),
        .o_underrun    (ur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [DS-1:0] l, input logic [DS-1:0] r);
        return {l, {(32-DS){1'b0}}, r, {(32-DS){1'b0}}};
    endfunction

    // ---------------- reference model ----------------
    int          m_cyc;
    bit          m_active;
    bit          m_full;
    bit          m_ready;
    bit          exp_fs;
    bit          exp_ur;
    logic [63:0] m_hold;
    logic [63:0] m_cur;
    logic [63:0] m_prev;

    // Advance the model by the posedge that just went by; inputs are driven
    // one time unit after negedge, so the values seen here are the ones that
    // edge sampled.
    task automatic model_step();
        bit pre_ready;
        if (!rst_n) begin
            m_active = 0; m_full = 0; m_ready = 1;
            exp_fs = 0; exp_ur = 0;
            m_cur = '0; m_prev = '0;
            return;
        end
        exp_fs = 0; exp_ur = 0;
        pre_ready = m_ready;
        if (en) begin
            if (!m_active) begin
                m_active = 1; m_cyc = 0; m_cur = '0; m_prev = '0;
            end else begin
                m_cyc++;
            end
            if ((m_cyc + 1) >= 2 * H && ((m_cyc + 1 - 2 * H) % FRAME) == 0) begin
                m_prev = m_cur;
                exp_fs = 1;
                if (m_full) begin
                    m_cur  = m_hold;
                    m_full = 0;
                end else begin
                    m_cur  = '0;
                    exp_ur = 1;
                end
            end
        end else begin
            m_active = 0;
        end
        if (bus.sample_valid && pre_ready) begin
            m_hold = mk_frame(bus.sample_left, bus.sample_right);
            m_full = 1;
        end
        m_ready = !m_full;
    endtask

    initial begin
        m_active = 0; m_full = 0; m_ready = 1; m_cyc = 0;
        m_cur = '0; m_prev = '0; m_hold = '0; exp_fs = 0; exp_ur = 0;
        forever begin
            int falls, k;
            logic e_sck, e_ws, e_sd;
            @(negedge clk);
            model_step();
            falls = m_active ? (m_cyc + 1) / (2 * H) : 0;
            k     = (62 + falls) % 64;
            e_sck = m_active ? (((m_cyc + 1) / H) % 2 == 1) : 1'b0;
            e_ws  = (falls > 0) && (k >= 31) && (k <= 62);
            if (falls == 0)   e_sd = 1'b0;
            else if (k == 63) e_sd = m_prev[0];
            else              e_sd = m_cur[63 - k];
            check_eq("ready",       64'(bus.sample_ready), 64'(m_ready));
            check_eq("frame_start", 64'(fs),  64'(exp_fs));
            check_eq("underrun",    64'(ur),  64'(exp_ur));
            check_eq("sck",         64'(sck), 64'(e_sck));
            check_eq("ws",          64'(ws),  64'(e_ws));
            check_eq("sd",          64'(sd),  64'(e_sd));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input int bound, input string tag);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (fs) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_eq(tag, 64'd0, 64'd1);
    endtask

    // Sample sd and ws on the next n SCK rising edges, first sample ends up MSB.
    task automatic collect_rises(input int n, output logic [63:0] sd_w, output logic [63:0] ws_w);
        logic prev;
        int   got = 0;
        sd_w = '0; ws_w = '0;
        prev = sck;
        for (int i = 0; i < n * 2 * H + 4 * H && got < n; i++) begin
            step();
            if (!prev && sck) begin
                sd_w = {sd_w[62:0], sd};
                ws_w = {ws_w[62:0], ws};
                got++;
            end
            prev = sck;
        end
        if (got != n) check_eq("rise_timeout", 64'(got), 64'(n));
    endtask

    task automatic skip_rises(input int n);
        logic [63:0] a, b;
        collect_rises(n, a, b);
    endtask

    task automatic push_pair(input logic [DS-1:0] l, input logic [DS-1:0] r);
        int i;
        bus.sample_valid = 1'b1;
        bus.sample_left  = l;
        bus.sample_right = r;
        for (i = 0; i < 2 * FRAME; i++) begin
            if (bus.sample_ready) break;
            step();
        end
        step();
        bus.sample_valid = 1'b0;
        if (i == 2 * FRAME) check_eq("push_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] sd_w, ws_w;
        logic [DS-1:0] cnt;
        int  n_ur, n_fs, n_acc;
        bit  prev_ready;

        rst_n = 1'b0; en = 1'b0;
        bus.sample_valid = 1'b0; bus.sample_left = '0; bus.sample_right = '0;

        // Reset values
        repeat (5) step();
        check_eq("rst_ready", 64'(bus.sample_ready), 64'd1);
        check_eq("rst_sck",   64'(sck), 64'd0);
        check_eq("rst_ws",    64'(ws),  64'd0);
        check_eq("rst_sd",    64'(sd),  64'd0);
        check_eq("rst_fs",    64'(fs),  64'd0);
        check_eq("rst_ur",    64'(ur),  64'd0);
        rst_n = 1'b1;
        step();

        // Single frame with known pair
        en = 1'b1;
        push_pair(24'hABCDEF, 24'h123456);
        check_eq("ready_drop", 64'(bus.sample_ready), 64'd0);
        wait_fs(4 * H, "fs1_timeout");
        check_eq("fs1_no_ur", 64'(ur), 64'd0);
        skip_rises(1);
        collect_rises(64, sd_w, ws_w);
        check_eq("left_word",  64'(sd_w[63:32]), 64'h00000000ABCDEF00);
        check_eq("right_word", 64'(sd_w[31:0]),  64'h0000000012345600);
        check_eq("ws_pattern", ws_w, 64'h00000001FFFFFFFE);

        // Underrun: two frames with nothing offered
        n_ur = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (ur) n_ur++;
        end
        check_eq("underrun_count", 64'(n_ur), 64'd2);

        // Recovery from underrun
        push_pair(DS'($urandom), DS'($urandom));
        n_ur = 0; n_fs = 0;
        for (int i = 0; i < FRAME - 4; i++) begin
            step();
            if (ur) n_ur++;
            if (fs) n_fs++;
        end
        check_eq("recover_ur", 64'(n_ur), 64'd0);
        check_eq("recover_fs", 64'(n_fs), 64'd1);

        // Backpressure: valid held, counter advances on every accept
        cnt = DS'($urandom);
        prev_ready = bus.sample_ready;
        bus.sample_valid = 1'b1;
        bus.sample_left  = cnt;
        bus.sample_right = cnt ^ DS'(24'h5A5A5A);
        n_acc = 0;
        for (int i = 0; i < 2 * FRAME + 8 * FRAME; i++) begin
            step();
            if (bus.sample_valid && prev_ready) begin
                n_acc++;
                cnt++;
                bus.sample_left  = cnt;
                bus.sample_right = cnt ^ DS'(24'h5A5A5A);
            end
            prev_ready = bus.sample_ready;
            if (fs && n_fs >= 0) begin
                n_acc = 0;
                n_fs  = -1;
                for (int j = 0; j < 8 * FRAME; j++) begin
                    step();
                    if (bus.sample_valid && prev_ready) begin
                        n_acc++;
                        cnt++;
                        bus.sample_left  = cnt;
                        bus.sample_right = cnt ^ DS'(24'h5A5A5A);
                    end
                    prev_ready = bus.sample_ready;
                end
                break;
            end
        end
        bus.sample_valid = 1'b0;
        check_eq("bp_accepts", 64'(n_acc), 64'd8);

        // Enable dropped at bit_cnt=40
        wait_fs(2 * FRAME, "fs_drop_timeout");
        repeat (41 * 2 * H + 5) step();
        en = 1'b0;
        step();
        check_eq("idle_sck", 64'(sck), 64'd0);
        check_eq("idle_ws",  64'(ws),  64'd0);
        check_eq("idle_sd",  64'(sd),  64'd0);
        push_pair(DS'($urandom), DS'($urandom));
        check_eq("hold_live", 64'(bus.sample_ready), 64'd0);
        repeat (20) step();
        en = 1'b1;
        wait_fs(4 * H, "fs_reen_timeout");
        check_eq("reen_ws", 64'(ws), 64'd0);
        check_eq("reen_ur", 64'(ur), 64'd0);

        // Asynchronous reset in the right slot with a pair held
        push_pair(DS'($urandom), DS'($urandom));
        repeat (45 * 2 * H) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sck",   64'(sck), 64'd0);
        check_eq("arst_ws",    64'(ws),  64'd0);
        check_eq("arst_sd",    64'(sd),  64'd0);
        check_eq("arst_ready", 64'(bus.sample_ready), 64'd1);
        repeat (3) step();
        rst_n = 1'b1;
        push_pair(DS'($urandom), DS'($urandom));
        wait_fs(4 * H, "fs_post_rst_timeout");
        check_eq("post_rst_ur", 64'(ur), 64'd0);
        repeat (FRAME + 10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
